// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver feeding a first-word fall-through byte FIFO
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rx,
    input  logic                              rd_en,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic HAS_PAR = (PARITY_EN != 0);
    localparam logic ODD     = (PARITY_ODD != 0);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                 rx_m, rx_s;
    logic [DW-1:0]        div;
    logic                 tick;
    state_t               state, state_n;
    logic [SW-1:0]        sc, sc_n;
    logic [BW-1:0]        bi, bi_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 armed, armed_n;
    logic                 par_bad, par_bad_n;
    logic                 push, ferr_n, perr_n;
    logic                 pop, accept;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (div == DW'(CLK_DIV - 1))
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign tick = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sc         <= '0;
            bi         <= '0;
            shreg      <= '0;
            armed      <= 1'b0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            sc         <= sc_n;
            bi         <= bi_n;
            shreg      <= shreg_n;
            armed      <= armed_n;
            par_bad    <= par_bad_n;
            frame_err  <= ferr_n;
            parity_err <= perr_n;
            overrun    <= push & ~accept;
        end
    end

    // Every sample point is the tick where sc reaches its terminal value; START uses half a bit to land mid-bit.
    always_comb begin
        state_n   = state;
        sc_n      = sc;
        bi_n      = bi;
        shreg_n   = shreg;
        armed_n   = armed;
        par_bad_n = par_bad;
        push      = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = S_START;
                        sc_n    = '0;
                    end
                end
                S_START: begin
                    if (sc == SW'(OVERSAMPLE / 2 - 1)) begin
                        if (rx_s) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n   = S_DATA;
                            sc_n      = '0;
                            bi_n      = '0;
                            shreg_n   = '0;
                            par_bad_n = 1'b0;
                        end
                    end else begin
                        sc_n = sc + 1'b1;
                    end
                end
                S_DATA: begin
                    if (sc == SW'(OVERSAMPLE - 1)) begin
                        sc_n         = '0;
                        shreg_n[bi]  = rx_s;
                        if (bi == BW'(DATA_BITS - 1))
                            state_n = HAS_PAR ? S_PARITY : S_STOP;
                        else
                            bi_n = bi + 1'b1;
                    end else begin
                        sc_n = sc + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (sc == SW'(OVERSAMPLE - 1)) begin
                        sc_n      = '0;
                        par_bad_n = ((^shreg) ^ rx_s) != ODD;
                        state_n   = S_STOP;
                    end else begin
                        sc_n = sc + 1'b1;
                    end
                end
                S_STOP: begin
                    if (sc == SW'(OVERSAMPLE - 1)) begin
                        sc_n    = '0;
                        state_n = S_IDLE;
                        armed_n = 1'b0;
                        if (!rx_s)
                            ferr_n = 1'b1;
                        else if (par_bad)
                            perr_n = 1'b1;
                        else
                            push = 1'b1;
                    end else begin
                        sc_n = sc + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // A full FIFO still takes a byte when the same cycle pops the head.
    assign pop    = rd_en & (count != '0);
    assign accept = push & ((count != DEPTH_C) | rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= shreg;
    end

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - table, directed and random checks of uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
    localparam int BIT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx0, rx1, rd0, rd1;
    logic [7:0] rdd0, rdd1;
    logic       e0, f0, e1, f1;
    logic [3:0] c0, c1;
    logic       fe0, pe0, ov0, fe1, pe1, ov1;

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_EN(0),
                   .PARITY_ODD(0), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rd_en(rd0), .rd_data(rdd0), .empty(e0),
        .full(f0), .count(c0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_EN(1),
                   .PARITY_ODD(0), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rd_en(rd1), .rd_data(rdd1), .empty(e1),
        .full(f1), .count(c1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

    int total = 0;
    int bad   = 0;
    int nfe [2] = '{0, 0};
    int npe [2] = '{0, 0};
    int nov [2] = '{0, 0};
    int efe [2] = '{0, 0};
    int epe [2] = '{0, 0};
    int eov [2] = '{0, 0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [5:0] prev_p = '0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         ex_fe;
        int         ex_pe;
        int         ex_push;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] cur;
        cur = {fe0, pe0, ov0, fe1, pe1, ov1};
        if (fe0) nfe[0]++;
        if (pe0) npe[0]++;
        if (ov0) nov[0]++;
        if (fe1) nfe[1]++;
        if (pe1) npe[1]++;
        if (ov1) nov[1]++;
        for (int i = 0; i < 6; i++) begin
            if (cur[i]) begin
                total++;
                if (prev_p[i]) begin
                    bad++;
                    $display("FAIL pulse_width bit%0d: got 2+ cycles expected 1", i);
                end
            end
        end
        prev_p = cur;
    end

    function automatic int qsize(input int w);
        return (w == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qfront(input int w);
        if (qsize(w) == 0) return 0;
        return (w == 0) ? int'(q0[0]) : int'(q1[0]);
    endfunction

    // 0 = byte stored, 1 = framing error, 2 = parity error (even parity on the parity DUT)
    function automatic int outcome(input int w, input logic [7:0] d, input logic par, input logic stop);
        if (!stop) return 1;
        if (w == 1 && (($countones(d) + int'(par)) % 2) != 0) return 2;
        return 0;
    endfunction

    task automatic set_rx(input int w, input logic v);
        if (w == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input int w, input logic [7:0] d, input logic par, input logic stop);
        set_rx(w, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            set_rx(w, d[i]);
            wait_clk(BIT);
        end
        if (w == 1) begin
            set_rx(w, par);
            wait_clk(BIT);
        end
        set_rx(w, stop);
        wait_clk(BIT);
    endtask

    task automatic send(input int w, input logic [7:0] d, input logic par, input logic stop);
        drive_frame(w, d, par, stop);
        set_rx(w, 1'b1);
        wait_clk(32);
    endtask

    task automatic check_state(input int w, input string tag);
        int cnt, rdv, emp, ful;
        cnt = (w == 0) ? int'(c0) : int'(c1);
        rdv = (w == 0) ? int'(rdd0) : int'(rdd1);
        emp = (w == 0) ? int'(e0) : int'(e1);
        ful = (w == 0) ? int'(f0) : int'(f1);
        check({tag, ".count"}, cnt, qsize(w));
        check({tag, ".empty"}, emp, int'(qsize(w) == 0));
        check({tag, ".full"}, ful, int'(qsize(w) == 8));
        check({tag, ".rd_data"}, rdv, qfront(w));
        check({tag, ".frame_err"}, nfe[w], efe[w]);
        check({tag, ".parity_err"}, npe[w], epe[w]);
        check({tag, ".overrun"}, nov[w], eov[w]);
    endtask

    task automatic model_send(input int w, input logic [7:0] d, input logic par,
                              input logic stop, input string tag);
        int oc;
        oc = outcome(w, d, par, stop);
        send(w, d, par, stop);
        if (oc == 1) efe[w]++;
        else if (oc == 2) epe[w]++;
        else if (qsize(w) == 8) eov[w]++;
        else if (w == 0) q0.push_back(d);
        else q1.push_back(d);
        check_state(w, tag);
    endtask

    task automatic do_read(input int w, input string tag);
        check({tag, ".head"}, (w == 0) ? int'(rdd0) : int'(rdd1), qfront(w));
        if (w == 0) rd0 = 1'b1; else rd1 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
        if (qsize(w) > 0) begin
            if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        check_state(w, {tag, ".after"});
    endtask

    initial begin
        logic [7:0] d;
        logic       par, stop;
        int         nr;

        tbl[0] = '{8'h07, 1'b1, 1'b1, 0, 0, 1};
        tbl[1] = '{8'h07, 1'b0, 1'b1, 0, 1, 0};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 0, 0, 1};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 0, 0, 1};
        tbl[4] = '{8'h80, 1'b0, 1'b0, 1, 0, 0};
        tbl[5] = '{8'h3C, 1'b1, 1'b1, 0, 1, 0};

        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rd0 = 1'b0; rd1 = 1'b0;
        wait_clk(3);
        check_state(0, "reset0");
        check_state(1, "reset1");
        rst_n = 1'b1;
        wait_clk(8);

        model_send(0, 8'hA5, 1'b0, 1'b1, "basic_a5");
        model_send(0, 8'h3C, 1'b0, 1'b1, "basic_3c");
        do_read(0, "basic_rd");

        for (int i = 0; i < 6; i++) begin
            int fe_b, pe_b, cnt_b;
            fe_b  = nfe[1];
            pe_b  = npe[1];
            cnt_b = int'(c1);
            send(1, tbl[i].data, tbl[i].par, tbl[i].stop);
            check($sformatf("tbl%0d.fe", i), nfe[1] - fe_b, tbl[i].ex_fe);
            check($sformatf("tbl%0d.pe", i), npe[1] - pe_b, tbl[i].ex_pe);
            check($sformatf("tbl%0d.cnt", i), int'(c1), cnt_b + tbl[i].ex_push);
            efe[1] += tbl[i].ex_fe;
            epe[1] += tbl[i].ex_pe;
            if (tbl[i].ex_push != 0) q1.push_back(tbl[i].data);
        end
        while (qsize(1) > 0) do_read(1, "tbl_drain");

        drive_frame(0, 8'h55, 1'b0, 1'b0);
        efe[0]++;
        wait_clk(20 * BIT);
        check_state(0, "break");
        set_rx(0, 1'b1);
        wait_clk(BIT);
        model_send(0, 8'h12, 1'b0, 1'b1, "after_break");

        set_rx(0, 1'b0);
        wait_clk(16);
        set_rx(0, 1'b1);
        wait_clk(2 * BIT);
        check_state(0, "glitch");
        model_send(0, 8'h81, 1'b0, 1'b1, "after_glitch");
        while (qsize(0) > 0) do_read(0, "drain0");

        for (int i = 0; i < 9; i++)
            model_send(0, 8'(i), 1'b0, 1'b1, $sformatf("fill%0d", i));
        check("fill.full", int'(f0), 1);
        check("fill.overrun", nov[0], eov[0]);
        while (qsize(0) > 0) do_read(0, "fill_rd");
        check("fill.empty", int'(e0), 1);

        for (int k = 0; k < 20; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par  = 1'($countones(d) % 2);
            if ($urandom_range(0, 3) == 0) par = ~par;
            model_send(1, d, par, stop, $sformatf("rnd%0d", k));
            nr = $urandom_range(0, 2);
            for (int j = 0; j < nr; j++)
                if (qsize(1) > 0) do_read(1, $sformatf("rnd_rd%0d", k));
        end

        model_send(0, 8'h11, 1'b0, 1'b1, "pre_rst1");
        model_send(0, 8'h22, 1'b0, 1'b1, "pre_rst2");
        d = 8'hF5;
        set_rx(0, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < 3; i++) begin
            set_rx(0, d[i]);
            wait_clk(BIT);
        end
        set_rx(0, d[3]);
        wait_clk(32);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.count", int'(c0), 0);
        check("rst_mid.empty", int'(e0), 1);
        q0.delete();
        q1.delete();
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(29);
        for (int i = 4; i < 8; i++) begin
            set_rx(0, d[i]);
            wait_clk(BIT);
        end
        set_rx(0, 1'b1);
        wait_clk(2 * BIT);
        check_state(0, "rst_tail");
        check_state(1, "rst_other");
        model_send(0, 8'h9C, 1'b0, 1'b1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with oversampled start/bit detection, optional parity, framing/parity/overrun detection, and an on-chip receive FIFO. It sits between the external serial input pin and the local bus logic. It replaces fixed 8-bit, single-clock-per-bit reception and a free-running byte store with a clean, flow-controlled byte stream.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..8, LSB first.
- OVERSAMPLE, 16: baud ticks per bit, even, ≥4.
- CLK_DIV, 4: clk cycles per baud tick, ≥1.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored if PARITY_EN=0.
- FIFO_DEPTH, 8: entries, power of two, ≥2.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rd_en  in  1  pop head entry this cycle; ignored when empty.
- rd_data  out  DATA_BITS  head entry (first-word fall-through); 0 when empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: good byte dropped, FIFO full.

## Operation
- rx passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value rx_s.
- Tick generator: counter 0..CLK_DIV-1 runs continuously; tick is asserted for one clk when the counter is at CLK_DIV-1.
- Arming: after reset, and after any frame ends, the receiver must see rx_s=1 on at least one tick before it may detect a start bit. This ensures a line held low (break) never produces repeated frames.
- FSM states: IDLE, START, DATA, PARITY, STOP. Sub-bit counter sc: 0..OVERSAMPLE-1. Bit index bi: 0..DATA_BITS-1.
  - IDLE: if armed and rx_s=0 on a tick, go to START with sc=0.
  - START: at sc=OVERSAMPLE/2-1, sample rx_s. If 1, treat it as a glitch: go to IDLE and stay armed. If 0, go to DATA with sc=0, bi=0.
  - DATA: every OVERSAMPLE ticks (sc wraps), shift rx_s into the shift register at position bi. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample once. parity_ok = (XOR of data bits ^ sample) == PARITY_ODD. Go to STOP.
  - STOP: sample once, then return to IDLE disarmed. Exactly one of the following applies:
    - stop=0: pulse frame_err, discard the byte.
    - stop=1 and parity fails: pulse parity_err, discard the byte.
    - Otherwise, push the byte. If the push is refused (see below), pulse overrun and drop the byte.
  - Frame error takes priority over parity error. At most one error pulse occurs per frame.
- FIFO: circular buffer with wrap-around pointers; count is kept explicitly.
  - Push is accepted when count<FIFO_DEPTH, or when count=FIFO_DEPTH and rd_en=1 in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pop when empty is ignored: pointers and count unchanged, no error raised.
- Reset mid-frame discards the partial byte, empties the FIFO, clears all pulses, and returns the FSM to IDLE disarmed.

## Timing
- Reset values: rd_data=0, empty=1, full=0, count=0, frame_err=0, parity_err=0, overrun=0.
- Bit period = CLK_DIV×OVERSAMPLE clk cycles. Samples fall at mid-bit relative to the detected falling edge, ±1 tick.
- Input latency: 2 clk from rx to rx_s.
- The push, or the error/overrun pulse, occurs on the clk following the stop-bit sample tick. Pulses last exactly 1 clk.
- FIFO outputs:
  - empty, count, full and rd_data update on the clk after a push or pop.
  - rd_data is valid whenever empty=0 and reflects the new head on the cycle after a pop.

## Test plan
Common setup: CLK_DIV=4, OVERSAMPLE=16 (64 clk per bit), DATA_BITS=8.
- Basic reception (PARITY_EN=0): send 0xA5 then 0x3C → count goes 1 then 2; rd_data=0xA5; after one rd_en, rd_data=0x3C. No error pulses.
- Parity check (PARITY_EN=1, even parity):
  - Send 0x07 with parity bit 1 → byte accepted.
  - Send 0x07 with parity bit 0 → parity_err pulses once; count unchanged.
- Framing and break:
  - Send 0x55 with stop bit 0 → frame_err pulses once, byte discarded.
  - Hold rx=0 for 20 bit periods → no further frames or errors.
  - Release rx to 1, then send 0x12 → byte 0x12 received correctly.
- Start glitch: pulse rx low for 16 clk, then high → no frame, no pulse, FSM back in IDLE; a following 0x81 is received normally.
- FIFO full (FIFO_DEPTH=8): send 9 bytes 0x00..0x08 without reading → full=1, count=8, overrun pulses on byte 0x08. Reads then return 0x00..0x07 in order, and empty=1 afterwards.
- Reset mid-frame: assert rst_n=0 during bit 3 of a frame while 2 bytes are queued → count=0 and empty=1 immediately; the remainder of the interrupted frame yields no byte; the next full frame is received correctly.
